// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters and
// registered sync/blanking outputs aligned with the x/y coordinates.
module vga_sync_gen #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       p_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] h_count, v_count;
    logic [9:0] h_next, v_next;
    logic       hsync_next, vsync_next, video_on_next;

    generate
        if (CLK_DIV <= 1) begin : g_no_div
            assign p_tick = 1'b1;
        end else begin : g_div
            localparam int               DIV_W    = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] div_cnt;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            always_ff @(posedge clk) begin
                if (reset || div_cnt >= DIV_LAST)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + 1'b1;
            end

            assign p_tick = (div_cnt == DIV_LAST);
        end
    endgenerate

    // Out-of-range counts (unreachable in normal operation) wrap to 0 on the next tick.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        h_next = h_count;
        v_next = v_count;
        if (p_tick) begin
            if (h_count >= H_LAST) begin
                h_next = '0;
                v_next = (v_count >= V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
                if (v_count > V_LAST)
                    v_next = '0;
            end
        end
    end

    always_comb begin
        hsync_next    = (h_next >= HS_START && h_next <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next    = (v_next >= VS_START && v_next <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    end

    // Flags are only reloaded on pixel ticks so the post-reset (0,0) pixel stays blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count    <= '0;
            v_count    <= '0;
            video_on   <= 1'b0;
            frame_tick <= 1'b0;
            hsync      <= ~SYNC_ACTIVE;
            vsync      <= ~SYNC_ACTIVE;
        end else begin
            h_count    <= h_next;
            v_count    <= v_next;
            frame_tick <= p_tick && (h_next == 10'd0) && (v_next == 10'd0);
            if (p_tick) begin
                video_on <= video_on_next;
                hsync    <= hsync_next;
                vsync    <= vsync_next;
            end
        end
    end

    assign x = h_count;
    assign y = v_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized-reset bench comparing three vga_sync_gen configurations against
// an arithmetic timing model derived from the clock count since reset.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic checking = 1'b0;
    int   k = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Clock edges since the last reset edge; the model is a pure function of it.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_von, a_hs, a_vs, a_pt, a_ft;
    logic b_von, b_hs, b_vs, b_pt, b_ft;
    logic c_von, c_hs, c_vs, c_pt, c_ft;

    vga_sync_gen dut_a (
        .clk(clk), .reset(reset), .x(a_x), .y(a_y), .video_on(a_von),
        .hsync(a_hs), .vsync(a_vs), .p_tick(a_pt), .frame_tick(a_ft)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .x(b_x), .y(b_y), .video_on(b_von),
        .hsync(b_hs), .vsync(b_vs), .p_tick(b_pt), .frame_tick(b_ft)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b0)
    ) dut_c (
        .clk(clk), .reset(reset), .x(c_x), .y(c_y), .video_on(c_von),
        .hsync(c_hs), .vsync(c_vs), .p_tick(c_pt), .frame_tick(c_ft)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Pixel index = completed ticks modulo frame size; everything follows from it.
    function automatic exp_t model(input int kk, input int d,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input logic sa);
        exp_t m;
        int ht, vt, t, p, hx, vy;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        t  = kk / d;
        p  = t % (ht * vt);
        hx = p % ht;
        vy = p / ht;
        m.x   = 10'(hx);
        m.y   = 10'(vy);
        m.pt  = ((kk % d) == d - 1);
        m.von = (t > 0) && (hx < hd) && (vy < vd);
        m.hs  = (hx >= hd + hf && hx < hd + hf + hsw) ? sa : ~sa;
        m.vs  = (vy >= vd + vf && vy < vd + vf + vsw) ? sa : ~sa;
        m.ft  = ((kk % d) == 0) && (t > 0) && (p == 0);
        return m;
    endfunction

    task automatic check_dut(input string name, input exp_t e,
                             input logic [9:0] ox, input logic [9:0] oy, input logic ovon,
                             input logic ohs, input logic ovs, input logic opt, input logic oft);
        check({name, ".x"},          32'(ox),   32'(e.x));
        check({name, ".y"},          32'(oy),   32'(e.y));
        check({name, ".video_on"},   32'(ovon), 32'(e.von));
        check({name, ".hsync"},      32'(ohs),  32'(e.hs));
        check({name, ".vsync"},      32'(ovs),  32'(e.vs));
        check({name, ".p_tick"},     32'(opt),  32'(e.pt));
        check({name, ".frame_tick"}, 32'(oft),  32'(e.ft));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_dut("A", model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0),
                      a_x, a_y, a_von, a_hs, a_vs, a_pt, a_ft);
            check_dut("B", model(k, 1, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1),
                      b_x, b_y, b_von, b_hs, b_vs, b_pt, b_ft);
            check_dut("C", model(k, 3, 10, 3, 4, 2, 6, 2, 2, 2, 1'b0),
                      c_x, c_y, c_von, c_hs, c_vs, c_pt, c_ft);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        run(3);
        checking = 1'b1;
        reset = 1'b0;
        // Three full lines of the default timing, many frames of the small ones.
        run(3 * 3200 + 100);
        for (int i = 0; i < 40; i++) begin
            reset = 1'b1;
            run($urandom_range(1, 3));
            reset = 1'b0;
            run($urandom_range(1, 1500));
        end
        run(10000);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
